// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter.
// Holds the FSM state encoding and requester-count helper.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int req_count(input int sel_width);
    return 1 << sel_width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit
// of req searching ptr+1, ptr+2, ... with wrap.
module rr_pick
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int SEL_WIDTH = 2,
  localparam int N = req_count(SEL_WIDTH)
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  logic [SEL_WIDTH-1:0] cand;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = ptr + SEL_WIDTH'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Packet-granular round-robin arbiter and bus mux.
// RR_MUX_ARBITER_OUT_REG_EN adds a 2-entry output skid buffer.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int SEL_WIDTH = 2,
  parameter  int DAT_WIDTH = 8,
  localparam int N = req_count(SEL_WIDTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N-1:0]                  req_vld_i,
  input  logic [N-1:0]                  req_last_i,
  input  logic [N-1:0][DAT_WIDTH-1:0]   req_dat_i,
  output logic [N-1:0]                  req_rdy_o,
  output logic [DAT_WIDTH-1:0]          dat_o,
  output logic                          vld_o,
  output logic                          last_o,
  input  logic                          rdy_i,
  output logic [SEL_WIDTH-1:0]          sel_o,
  output logic                          busy_o
);

  arb_state_t state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] pick_ptr, win;
  logic any_vld, busy;
  logic beat_vld, beat_last;
  logic [DAT_WIDTH-1:0] beat_dat;
  logic take, done, rdy_gate;

  assign busy      = state_q == ARB_BUSY;
  assign beat_vld  = busy & req_vld_i[sel_q];
  assign beat_last = beat_vld & req_last_i[sel_q];
  assign beat_dat  = req_dat_i[sel_q];
  // Regrant searches from the requester just served.
  assign pick_ptr  = busy ? sel_q : ptr_q;

  rr_pick #(
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .req(req_vld_i),
    .ptr(pick_ptr),
    .idx(win),
    .any(any_vld)
  );

`ifdef RR_MUX_ARBITER_OUT_REG_EN
  logic [1:0]         cnt_q;
  logic [DAT_WIDTH:0] ent0_q, ent1_q;
  logic [DAT_WIDTH:0] beat_ent;
  logic               in_rdy, pop;

  // Ready depends only on occupancy, never on rdy_i.
  assign in_rdy   = busy & (cnt_q != 2'd2);
  assign take     = beat_vld & in_rdy;
  assign pop      = (cnt_q != 2'd0) & rdy_i;
  assign beat_ent = {beat_last, beat_dat};
  assign rdy_gate = in_rdy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (take) begin
            ent0_q <= beat_ent;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (take && pop) begin
            ent0_q <= beat_ent;
          end else if (take) begin
            ent1_q <= beat_ent;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            ent0_q <= ent1_q;
            cnt_q  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign vld_o           = cnt_q != 2'd0;
  assign {last_o, dat_o} = vld_o ? ent0_q : '0;
`else
  assign take     = beat_vld & rdy_i;
  assign rdy_gate = busy & rdy_i;
  assign vld_o    = beat_vld;
  assign last_o   = beat_last;
  assign dat_o    = busy ? beat_dat : '0;
`endif

  assign done = take & req_last_i[sel_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      ptr_q   <= SEL_WIDTH'(N - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_vld) begin
          state_d = ARB_BUSY;
          sel_d   = win;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          ptr_d = sel_q;
          if (any_vld) begin
            sel_d = win;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    req_rdy_o = '0;
    sel_o     = '0;
    busy_o    = 1'b0;
    unique case (state_q)
      ARB_BUSY: begin
        req_rdy_o[sel_q] = rdy_gate;
        sel_o            = sel_q;
        busy_o           = 1'b1;
      end
      ARB_IDLE: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule
